// File: rtl/maxnet_controller.sv
// maxnet_controller
//   Sequencer for a four-PLU MAXNET datapath. It loads the initial activations,
//   then repeats: start the PLUs, wait for them, write back the results, and
//   look at the winner check. The loop ends with a done pulse or a sticky error.
//
//   Optional build macro: MAXNET_CTRL_TIMEOUT_EN adds a per-pass watchdog in WAIT.
//   Without the macro, WAIT waits indefinitely.
//
//   Parameters
//     MAX_ITER        iteration limit before error (1..255)
//     TIMEOUT_CYCLES  WAIT watchdog length (timeout build only)
//   Ports
//     clk, rst        clock; asynchronous active-high reset
//     start_in        host request, accepted in IDLE or ERR
//     plu_done        all PLUs finished this pass
//     finish          datapath reports a single winner
//     overflow        any PLU overflowed
//     rst_plu, eps_reg_we, we_a_reg, we_prim, mux_sel, plu_start
//                     datapath strobes, decoded from the state register
//     busy, done, error
//                     status: run active, completion pulse, sticky fault
//     iter_count      completed iterations, saturating at 255
//     err_code        00 none, 01 overflow, 10 iteration limit, 11 timeout
//
//   state  | meaning
//   IDLE   | PLUs held in clear, waiting for start_in
//   LOAD   | capture epsilon and initial activations
//   RUN    | one-cycle PLU start pulse
//   WAIT   | PLUs computing
//   UPDATE | write PLU results back into the activation register
//   CHECK  | let the registered winner check settle, then decide
//   CLR    | clear the PLUs before the next pass
//   DONE   | one-cycle completion pulse
//   ERR    | fault reported, waiting for a new start_in
module maxnet_controller #(
  parameter int unsigned MAX_ITER       = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic       plu_done,
  input  logic       finish,
  input  logic       overflow,
  output logic       rst_plu,
  output logic       eps_reg_we,
  output logic       we_a_reg,
  output logic       we_prim,
  output logic       mux_sel,
  output logic       plu_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] iter_count,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_RUN, S_WAIT, S_UPDATE, S_CHECK, S_CLR, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_ITER = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;
  localparam logic [7:0] ITER_LIM = 8'(MAX_ITER);

  state_t     state, state_nxt;
  logic [1:0] err_code_nxt;
  logic       start_accept;
  logic       tmo_hit;

`ifdef MAXNET_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  // Loaded in RUN so the count starts fresh on every entry into WAIT;
  // reaching zero on the TIMEOUT_CYCLES-th WAIT cycle trips the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state == S_RUN)
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if ((state == S_WAIT) && (tmo_cnt != '0))
      tmo_cnt <= tmo_cnt - TW'(1);
  end

  assign tmo_hit = (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  assign start_accept = start_in && ((state == S_IDLE) || (state == S_ERR));

  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code;
    case (state)
      S_IDLE:   if (start_in) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_RUN;
      S_RUN:    state_nxt = S_WAIT;
      S_WAIT: begin
        // overflow wins over a simultaneous plu_done so corrupt results are never written back
        if (overflow) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_OVF;
        end else if (plu_done) begin
          state_nxt = S_UPDATE;
        end else if (tmo_hit) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_TMO;
        end
      end
      S_UPDATE: state_nxt = S_CHECK;
      S_CHECK: begin
        if (finish) begin
          state_nxt = S_DONE;
        end else if (iter_count == ITER_LIM) begin
          state_nxt    = S_ERR;
          err_code_nxt = ERR_ITER;
        end else begin
          state_nxt = S_CLR;
        end
      end
      S_CLR:    state_nxt = S_RUN;
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    if (start_in) state_nxt = S_LOAD;
      default:  state_nxt = S_IDLE;
    endcase
    if (start_accept) err_code_nxt = ERR_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      err_code   <= ERR_NONE;
      iter_count <= 8'd0;
    end else begin
      state    <= state_nxt;
      err_code <= err_code_nxt;
      if (start_accept)
        iter_count <= 8'd0;
      else if ((state == S_UPDATE) && (iter_count != 8'hFF))
        iter_count <= iter_count + 8'd1;
    end
  end

  always_comb begin
    rst_plu    = 1'b0;
    eps_reg_we = 1'b0;
    we_a_reg   = 1'b0;
    we_prim    = 1'b0;
    mux_sel    = 1'b0;
    plu_start  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE:   rst_plu = 1'b1;
      S_LOAD: begin
        rst_plu    = 1'b1;
        eps_reg_we = 1'b1;
        we_a_reg   = 1'b1;
        we_prim    = 1'b1;
        mux_sel    = 1'b1;
        busy       = 1'b1;
      end
      S_RUN: begin
        plu_start = 1'b1;
        busy      = 1'b1;
      end
      S_WAIT:   busy = 1'b1;
      S_UPDATE: begin
        we_a_reg = 1'b1;
        busy     = 1'b1;
      end
      S_CHECK:  busy = 1'b1;
      S_CLR: begin
        rst_plu = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:   done  = 1'b1;
      S_ERR:    error = 1'b1;
      default:  rst_plu = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller
//   Randomized and directed stimulus for maxnet_controller, checked every cycle
//   against a behavioural model of the sequencing rules, plus literal
//   expectations for the key scenarios.
module tb_maxnet_controller;

  localparam int MAX_ITER       = 3;
  localparam int TIMEOUT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst, start_in, plu_done, finish, overflow;
  logic       rst_plu, eps_reg_we, we_a_reg, we_prim, mux_sel, plu_start;
  logic       busy, done, error;
  logic [7:0] iter_count;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  maxnet_controller #(
    .MAX_ITER      (MAX_ITER),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .plu_done  (plu_done),
    .finish    (finish),
    .overflow  (overflow),
    .rst_plu   (rst_plu),
    .eps_reg_we(eps_reg_we),
    .we_a_reg  (we_a_reg),
    .we_prim   (we_prim),
    .mux_sel   (mux_sel),
    .plu_start (plu_start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .iter_count(iter_count),
    .err_code  (err_code)
  );

  // Model phases of a run, named after what the datapath is doing.
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_WAIT = 3, P_UPDATE = 4;
  localparam int P_CHECK = 5, P_CLR = 6, P_DONE = 7, P_ERR = 8;

  int m_phase, m_iter, m_code, m_wait;
  int n_checks = 0;
  int n_errors = 0;
  int cnt_pstart, cnt_eps, cnt_wea, cnt_done;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_iter  = 0;
    m_code  = 0;
    m_wait  = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      P_IDLE, P_ERR:
        if (start_in) begin
          m_phase = P_LOAD;
          m_iter  = 0;
          m_code  = 0;
        end
      P_LOAD:   m_phase = P_RUN;
      P_RUN: begin
        m_phase = P_WAIT;
        m_wait  = 0;
      end
      P_WAIT: begin
        if (overflow) begin
          m_phase = P_ERR;
          m_code  = 1;
        end else if (plu_done) begin
          m_phase = P_UPDATE;
        end else begin
          m_wait++;
`ifdef MAXNET_CTRL_TIMEOUT_EN
          if (m_wait >= TIMEOUT_CYCLES) begin
            m_phase = P_ERR;
            m_code  = 3;
          end
`endif
        end
      end
      P_UPDATE: begin
        m_iter  = (m_iter >= 255) ? 255 : m_iter + 1;
        m_phase = P_CHECK;
      end
      P_CHECK: begin
        if (finish) m_phase = P_DONE;
        else if (m_iter == MAX_ITER) begin
          m_phase = P_ERR;
          m_code  = 2;
        end else m_phase = P_CLR;
      end
      P_CLR:    m_phase = P_RUN;
      default:  m_phase = P_IDLE;
    endcase
  endtask

  // Expected output word: {rst_plu,eps,we_a,we_prim,mux,plu_start,busy,done,error,iter,code}
  function automatic int expected_word();
    bit e_rst_plu, e_load, e_wea, e_busy;
    e_rst_plu = (m_phase == P_IDLE) || (m_phase == P_LOAD) || (m_phase == P_CLR);
    e_load    = (m_phase == P_LOAD);
    e_wea     = (m_phase == P_LOAD) || (m_phase == P_UPDATE);
    e_busy    = (m_phase >= P_LOAD) && (m_phase <= P_CLR);
    return {e_rst_plu, e_load, e_wea, e_load, e_load, (m_phase == P_RUN), e_busy,
            (m_phase == P_DONE), (m_phase == P_ERR)} * 1024 + m_iter * 4 + m_code;
  endfunction

  function automatic int actual_word();
    return {rst_plu, eps_reg_we, we_a_reg, we_prim, mux_sel, plu_start, busy, done, error}
           * 1024 + int'(iter_count) * 4 + int'(err_code);
  endfunction

  task automatic compare_cycle();
    check("cycle_outputs", actual_word(), expected_word());
    if (plu_start)  cnt_pstart++;
    if (eps_reg_we) cnt_eps++;
    if (we_a_reg)   cnt_wea++;
    if (done)       cnt_done++;
  endtask

  task automatic clear_tally();
    cnt_pstart = 0;
    cnt_eps    = 0;
    cnt_wea    = 0;
    cnt_done   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare_cycle();
  endtask

  // Reset asserted away from the clock edge; the DUT must react without a clock.
  task automatic assert_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_cycle();
  endtask

  task automatic wait_for(input bit want_err, input int bound, input string nm);
    int k = 0;
    while (!(want_err ? error : done) && k < bound) begin
      tick();
      k++;
    end
    check(nm, want_err ? int'(error) : int'(done), 1);
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; plu_done = 1'b0; finish = 1'b0; overflow = 1'b0;
    model_reset();
    clear_tally();
    @(negedge clk);
    compare_cycle();
    check("reset_busy", busy, 0);
    check("reset_rst_plu", rst_plu, 1);
    check("reset_iter", iter_count, 0);
    check("reset_err_code", err_code, 0);
    check("reset_error", error, 0);
    rst = 1'b0;
    tick();

    // single pass: winner found in the first CHECK
    clear_tally();
    start_in = 1'b1; tick(); start_in = 1'b0;
    check("load_eps", eps_reg_we, 1);
    check("load_mux", mux_sel, 1);
    tick();
    check("run_pulse", plu_start, 1);
    repeat (5) tick();
    plu_done = 1'b1; finish = 1'b1;
    wait_for(1'b0, 10, "done_wait");
    plu_done = 1'b0; finish = 1'b0;
    check("single_iter", iter_count, 1);
    tick();
    check("idle_iter_hold", iter_count, 1);
    check("idle_busy", busy, 0);
    check("single_pstart", cnt_pstart, 1);
    check("single_eps", cnt_eps, 1);
    check("single_done", cnt_done, 1);
    check("single_wea", cnt_wea, 2);

    // iteration limit with finish held low
    clear_tally();
    plu_done = 1'b1; start_in = 1'b1; tick(); start_in = 1'b0;
    wait_for(1'b1, 60, "limit_wait");
    plu_done = 1'b0;
    check("limit_pstart", cnt_pstart, 3);
    check("limit_err_code", err_code, 2);
    check("limit_iter", iter_count, 3);
    check("model_pin_iter", m_iter, 3);
    tick(); tick();
    check("error_sticky", error, 1);

    // restart from ERR, then start_in during WAIT is ignored
    clear_tally();
    start_in = 1'b1; tick(); start_in = 1'b0;
    check("restart_error", error, 0);
    check("restart_load", eps_reg_we, 1);
    check("restart_code", err_code, 0);
    tick(); tick();
    start_in = 1'b1; tick(); tick(); start_in = 1'b0;
    check("wait_start_ignored", cnt_eps, 1);
    check("wait_busy", busy, 1);

    // overflow together with plu_done
    cnt_wea = 0;
    overflow = 1'b1; plu_done = 1'b1; tick(); overflow = 1'b0; plu_done = 1'b0;
    check("ovf_error", error, 1);
    check("ovf_code", err_code, 1);
    tick(); tick();
    check("ovf_no_update", cnt_wea, 0);

    // stall in WAIT
    start_in = 1'b1; tick(); start_in = 1'b0; tick(); tick();
`ifdef MAXNET_CTRL_TIMEOUT_EN
    begin
      int k = 1;
      while (!error && k < 40) begin
        tick();
        if (!error) k++;
      end
      check("tmo_wait_cycles", k, TIMEOUT_CYCLES);
      check("tmo_code", err_code, 3);
    end
`else
    repeat (1000) tick();
    check("stall_busy", busy, 1);
    check("stall_error", error, 0);
`endif

    // reset in the middle of WAIT after one completed iteration
    start_in = 1'b1; tick(); start_in = 1'b0; tick(); tick();
    plu_done = 1'b1; tick(); plu_done = 1'b0;
    repeat (4) tick();
    check("pre_reset_iter", iter_count, 1);
    assert_reset();
    check("midrst_busy", busy, 0);
    check("midrst_rst_plu", rst_plu, 1);
    check("midrst_iter", iter_count, 0);
    tick();
    check("midrst_next_busy", busy, 0);
    rst = 1'b0;
    start_in = 1'b1; tick(); start_in = 1'b0;
    check("first_start_after_reset", eps_reg_we, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        tick();
        rst = 1'b0;
      end
      start_in = ($urandom_range(0, 9) < 3);
      plu_done = ($urandom_range(0, 9) < 3);
      overflow = ($urandom_range(0, 39) == 0);
      finish   = ($urandom_range(0, 9) < 4);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
